// File: rtl/uart_sram_tx_if.sv
// +----------------------------------------------------------------------------+
// | uart_sram_tx_if: start/SRAM/UART bundle for the SRAM-to-UART dump engine.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface uart_sram_tx_if;
  logic        Start;
  logic [17:0] Start_address;
  logic [17:0] Word_count;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, Start_address, Word_count, SRAM_read_data,
    input  SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
  );

  modport slave (
    input  Start, Start_address, Word_count, SRAM_read_data,
    output SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
  );
endinterface

`default_nettype wire

// File: rtl/uart_sram_tx_interface.sv
// +----------------------------------------------------------------------------+
// | uart_sram_tx_interface: reads 16-bit SRAM words, sends them hi byte first  |
// | as 8N1 frames. Optional macro UART_TX_CHECKSUM_EN appends an XOR frame.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_sram_tx_interface #(
  parameter int CLK_DIV      = 434,
  parameter int SRAM_LATENCY = 2    // must be >= 2
) (
  input  wire logic     Clock,
  input  wire logic     Resetn,
  uart_sram_tx_if.slave bus
);

  localparam int                  c_baud_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLK_DIV - 1);
  localparam logic [7:0]          c_wait_last = 8'(SRAM_LATENCY - 2);

  typedef enum logic [3:0] {
    S_TX_IDLE, S_TX_ADDR, S_TX_WAIT, S_TX_LATCH,
    S_TX_SEND_HI, S_TX_SEND_LO, S_TX_NEXT, S_TX_DONE
`ifdef UART_TX_CHECKSUM_EN
    , S_TX_SUM
`endif
  } state_t;

  state_t              r_state;
  logic [17:0]         r_addr;
  logic [17:0]         r_remaining;
  logic [7:0]          r_wait_cnt;
  logic [7:0]          r_lo_byte;
  logic                r_busy;
  logic                r_done;
`ifdef UART_TX_CHECKSUM_EN
  logic [7:0]          r_sum;
  logic                r_sum_sent;
`endif

  logic [8:0]          r_shift;
  logic [c_baud_w-1:0] r_baud;
  logic [3:0]          r_bit_idx;
  logic                r_tx_busy;
  logic                r_tx;

  logic                w_byte_done;
  logic                w_tx_start;
  logic [7:0]          w_tx_byte;

  assign w_byte_done = r_tx_busy && (r_bit_idx == 4'd9) && (r_baud == c_baud_last);

  // The high byte goes straight from the SRAM bus so its frame starts on the latch edge.
  always_comb begin
    w_tx_start = 1'b0;
    w_tx_byte  = 8'h00;
    case (r_state)
      S_TX_LATCH: begin
        w_tx_start = 1'b1;
        w_tx_byte  = bus.SRAM_read_data[15:8];
      end
      S_TX_SEND_HI: begin
        w_tx_start = w_byte_done;
        w_tx_byte  = r_lo_byte;
      end
`ifdef UART_TX_CHECKSUM_EN
      S_TX_SUM: begin
        w_tx_start = !r_sum_sent;
        w_tx_byte  = r_sum;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= S_TX_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_wait_cnt  <= '0;
      r_lo_byte   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
      r_sum       <= '0;
      r_sum_sent  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_TX_IDLE: begin
          if (bus.Start) begin
            r_addr      <= bus.Start_address;
            r_remaining <= bus.Word_count;
            r_busy      <= 1'b1;
`ifdef UART_TX_CHECKSUM_EN
            r_sum       <= '0;
            r_sum_sent  <= 1'b0;
            r_state     <= (bus.Word_count == '0) ? S_TX_SUM : S_TX_ADDR;
`else
            r_state     <= (bus.Word_count == '0) ? S_TX_DONE : S_TX_ADDR;
`endif
          end
        end
        S_TX_ADDR: begin
          r_wait_cnt <= '0;
          r_state    <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (r_wait_cnt == c_wait_last) r_state <= S_TX_LATCH;
          else                           r_wait_cnt <= r_wait_cnt + 8'd1;
        end
        S_TX_LATCH: begin
          r_lo_byte <= bus.SRAM_read_data[7:0];
          r_state   <= S_TX_SEND_HI;
        end
        S_TX_SEND_HI: if (w_byte_done) r_state <= S_TX_SEND_LO;
        S_TX_SEND_LO: if (w_byte_done) r_state <= S_TX_NEXT;
        S_TX_NEXT: begin
          r_addr      <= r_addr + 18'd1;
          r_remaining <= r_remaining - 18'd1;
          if (r_remaining == 18'd1) begin
`ifdef UART_TX_CHECKSUM_EN
            r_sum_sent <= 1'b0;
            r_state    <= S_TX_SUM;
`else
            r_state    <= S_TX_DONE;
`endif
          end else begin
            r_state <= S_TX_ADDR;
          end
        end
`ifdef UART_TX_CHECKSUM_EN
        S_TX_SUM: begin
          if (!r_sum_sent)      r_sum_sent <= 1'b1;
          else if (w_byte_done) r_state    <= S_TX_DONE;
        end
`endif
        S_TX_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_TX_IDLE;
        end
        default: r_state <= S_TX_IDLE;
      endcase
`ifdef UART_TX_CHECKSUM_EN
      if (w_tx_start && (r_state != S_TX_SUM)) r_sum <= r_sum ^ w_tx_byte;
`endif
    end
  end

  // Bit engine: r_shift holds {stop, d7..d0}; the start bit is driven at load time.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_shift   <= '1;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_tx_busy <= 1'b0;
      r_tx      <= 1'b1;
    end else if (w_tx_start) begin
      r_shift   <= {1'b1, w_tx_byte};
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_tx_busy <= 1'b1;
      r_tx      <= 1'b0;
    end else if (r_tx_busy) begin
      if (r_baud == c_baud_last) begin
        r_baud <= '0;
        if (r_bit_idx == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_tx      <= 1'b1;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          r_tx      <= r_shift[0];
          r_shift   <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_baud <= r_baud + 1'b1;
      end
    end
  end

  assign bus.SRAM_address = r_addr;
  assign bus.SRAM_we_n    = 1'b1;
  assign bus.UART_TX_O    = r_tx;
  assign bus.Busy         = r_busy;
  assign bus.Done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_sram_tx_interface.sv
// +----------------------------------------------------------------------------+
// | tb_uart_sram_tx_interface: SRAM model, UART receiver and byte scoreboard.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_sram_tx_interface;
  localparam int CLK_DIV = 434;

  typedef struct packed {
    logic        chk;
    logic [17:0] addr;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    logic [17:0]       addr;
    logic [17:0]       cnt;
    logic [2:0][15:0]  w;
    bit                inject;
  } vec_t;

  logic clk;
  logic Resetn;
  uart_sram_tx_if bus();

  uart_sram_tx_interface #(.CLK_DIV(CLK_DIV), .SRAM_LATENCY(2)) dut (
    .Clock  (clk),
    .Resetn (Resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   we_low = 0;
  int   low_cnt = 0;
  bit   rec_en = 0;
  logic prev_tx = 1'b1;
  int   edges[$];
  exp_t sb[$];

  logic [15:0] mem [int];
  logic [15:0] rd1, rd2;

  // Two-stage read pipeline: data valid two cycles after the address appears.
  always @(posedge clk) begin
    rd1 <= mem.exists(int'(bus.SRAM_address)) ? mem[int'(bus.SRAM_address)] : 16'h0000;
    rd2 <= rd1;
  end
  assign bus.SRAM_read_data = rd2;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.Done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.SRAM_we_n !== 1'b1) we_low++;
    if (bus.UART_TX_O === 1'b0) low_cnt++;
    if (rec_en && (bus.UART_TX_O !== prev_tx)) edges.push_back(cyc);
    prev_tx = bus.UART_TX_O;
  end

  task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic c, input logic [17:0] a, input logic [7:0] d);
    exp_t e;
    e.chk = c; e.addr = a; e.data = d;
    return e;
  endfunction

  // Receiver: samples mid-bit, drops frames cut by reset, pops the scoreboard.
  initial begin
    logic rprev;
    rprev = 1'b1;
    forever begin
      @(negedge clk);
      if (Resetn && rprev && (bus.UART_TX_O === 1'b0)) begin
        logic [9:0]  f;
        logic        ab;
        logic [17:0] a;
        exp_t        e;
        a = bus.SRAM_address; ab = 1'b0; f = '0;
        for (int k = 1; k <= CLK_DIV/2 + 9*CLK_DIV; k++) begin
          @(negedge clk);
          if (!Resetn) ab = 1'b1;
          if (k >= CLK_DIV/2 && ((k - CLK_DIV/2) % CLK_DIV) == 0)
            f[(k - CLK_DIV/2) / CLK_DIV] = bus.UART_TX_O;
        end
        if (!ab) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL rx_unexpected: got frame %0h want none", f);
          end else begin
            e = sb.pop_front();
            check_eq("rx_data", {24'h0, f[8:1]}, {24'h0, e.data});
            check_eq("rx_start_bit", {31'h0, f[0]}, 32'h0);
            check_eq("rx_stop_bit", {31'h0, f[9]}, 32'h1);
            if (e.chk) check_eq("rx_addr", {14'h0, a}, {14'h0, e.addr});
          end
        end
      end
      rprev = bus.UART_TX_O;
    end
  end

  task automatic pulse_start(input logic [17:0] a, input logic [17:0] n);
    @(negedge clk);
    bus.Start = 1'b1; bus.Start_address = a; bus.Word_count = n;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic run_xfer(input logic [17:0] a, input logic [17:0] n,
                          input logic [2:0][15:0] w, input bit inject, output int lat);
    logic [7:0]  sum;
    logic [17:0] wa;
    int d0, t0, budget;
    sum = 8'h00;
    for (int i = 0; i < int'(n); i++) begin
      wa = a + 18'(i);
      mem[int'(wa)] = w[i];
      sb.push_back(mk(1'b1, wa, w[i][15:8]));
      sb.push_back(mk(1'b1, wa, w[i][7:0]));
      sum = sum ^ w[i][15:8] ^ w[i][7:0];
    end
`ifdef UART_TX_CHECKSUM_EN
    sb.push_back(mk(1'b0, 18'h0, sum));
`endif
    d0 = done_cnt;
    pulse_start(a, n);
    t0 = cyc;
    if (inject) begin
      repeat (300) @(negedge clk);
      pulse_start(18'h02000, 18'd5);
    end
    budget = (2*int'(n) + 1) * 10 * CLK_DIV + 50 * (int'(n) + 1) + 100;
    while (done_cnt == d0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("done_seen", {31'h0, done_cnt != d0}, 32'h1);
    lat = done_cyc - t0;
    repeat (20) @(negedge clk);
    check_eq("frames_drained", sb.size(), 0);
    check_eq("single_done", done_cnt - d0, 1);
    sb.delete();
  endtask

  vec_t vecs[3];

  initial begin
    int viol, lat, base, d0, lo0, b;
    vecs[0] = '{addr: 18'h09600, cnt: 18'd1, w: {16'h0000, 16'h0000, 16'hA55A}, inject: 1'b0};
    vecs[1] = '{addr: 18'h00100, cnt: 18'd3, w: {16'h0506, 16'h0304, 16'h0102}, inject: 1'b1};
    vecs[2] = '{addr: 18'h3FFFF, cnt: 18'd2, w: {16'h0000, 16'h8001, 16'h1234}, inject: 1'b0};

    Resetn = 1'b0;
    bus.Start = 1'b0; bus.Start_address = '0; bus.Word_count = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", {31'h0, bus.UART_TX_O}, 32'h1);
    check_eq("rst_busy", {31'h0, bus.Busy}, 32'h0);
    check_eq("rst_done", {31'h0, bus.Done}, 32'h0);
    check_eq("rst_we_n", {31'h0, bus.SRAM_we_n}, 32'h1);
    check_eq("rst_addr", {14'h0, bus.SRAM_address}, 32'h0);
    Resetn = 1'b1;

    viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.UART_TX_O !== 1'b1 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.SRAM_we_n !== 1'b1)
        viol++;
    end
    check_eq("idle_quiet", viol, 0);

    for (int v = 0; v < 3; v++) begin
      if (v == 0) begin
        edges.delete();
        rec_en = 1'b1;
      end
      run_xfer(vecs[v].addr, vecs[v].cnt, vecs[v].w, vecs[v].inject, lat);
      if (v == 0) begin
        rec_en = 1'b0;
        if (edges.size() >= 3) begin
          check_eq("start_bit_width", edges[1] - edges[0], CLK_DIV);
          check_eq("bit1_width", edges[2] - edges[1], CLK_DIV);
        end else begin
          check_eq("edge_count", edges.size(), 3);
        end
`ifdef UART_TX_CHECKSUM_EN
        base = 3 * 10 * CLK_DIV;
`else
        base = 2 * 10 * CLK_DIV;
`endif
        check_eq("done_latency_ok", {31'h0, (lat > base) && (lat <= base + 20)}, 32'h1);
      end
    end

    // Zero-length transfer.
`ifdef UART_TX_CHECKSUM_EN
    run_xfer(18'h00055, 18'd0, '0, 1'b0, lat);
`else
    lo0 = low_cnt;
    d0  = done_cnt;
    pulse_start(18'h00055, 18'd0);
    check_eq("zero_busy", {31'h0, bus.Busy}, 32'h1);
    check_eq("zero_done_early", {31'h0, bus.Done}, 32'h0);
    @(negedge clk);
    check_eq("zero_done", {31'h0, bus.Done}, 32'h1);
    check_eq("zero_busy_clear", {31'h0, bus.Busy}, 32'h0);
    repeat (20) @(negedge clk);
    check_eq("zero_line_low", low_cnt - lo0, 0);
    check_eq("zero_done_count", done_cnt - d0, 1);
`endif

    // Reset in the middle of the first frame.
    pulse_start(18'h09600, 18'd1);
    b = 100;
    while (bus.UART_TX_O === 1'b1 && b > 0) begin
      @(negedge clk);
      b--;
    end
    check_eq("rst_frame_started", {31'h0, bus.UART_TX_O}, 32'h0);
    repeat (4 * CLK_DIV + CLK_DIV/2) @(negedge clk);
    d0 = done_cnt;
    Resetn = 1'b0;
    #1;
    check_eq("midrst_tx_high", {31'h0, bus.UART_TX_O}, 32'h1);
    @(negedge clk);
    check_eq("midrst_busy", {31'h0, bus.Busy}, 32'h0);
    repeat (3) @(negedge clk);
    Resetn = 1'b1;
    repeat (10 * CLK_DIV + 100) @(negedge clk);
    check_eq("midrst_no_done", done_cnt - d0, 0);
    run_xfer(vecs[0].addr, vecs[0].cnt, vecs[0].w, 1'b0, lat);

    check_eq("we_n_never_low", we_low, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
